// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: modes, op codes and FSM states.
package alu_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Arithmetic op_sel encodings
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // Logic op_sel encodings; 100-111 produce zero
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Carry fed into bit 0; logic mode always starts (and stays) at zero.
  function automatic logic init_carry(input logic mode, input logic [2:0] sel,
                                      input logic cin);
    logic c;
    c = 1'b0;
    if (mode == MODE_ARITH) begin
      case (sel)
        OP_SUB, OP_INC: c = 1'b1;
        OP_SBB, OP_ADC: c = cin;
        default:        c = 1'b0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: operand-B selection, full adder and logic functions.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       mode,
  input  logic [2:0] operation,
  input  logic       cin,
  output logic       out,
  output logic       carry_out
);

  logic b_sel;

  // Second arithmetic operand bit chosen by the op code
  always_comb begin
    b_sel = 1'b0;
    case (operation)
      OP_ADD, OP_ADC: b_sel = b;
      OP_SUB, OP_SBB: b_sel = ~b;
      OP_DEC:         b_sel = 1'b1;
      default:        b_sel = 1'b0;
    endcase
  end

  // Full adder in arithmetic mode, bitwise function in logic mode
  always_comb begin
    out       = 1'b0;
    carry_out = 1'b0;
    if (mode == MODE_ARITH) begin
      out       = a ^ b_sel ^ cin;
      carry_out = (a & b_sel) | (cin & (a ^ b_sel));
    end else begin
      case (operation)
        OP_AND:  out = a & b;
        OP_OR:   out = a | b;
        OP_XOR:  out = a ^ b;
        OP_NOTA: out = ~a;
        default: out = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: accepts one request, processes one bit per clock LSB first,
// then holds the result and flags until the consumer takes them.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_mode,
  input  logic [2:0]       op_sel,
  input  logic             op_cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             overflow
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             mode_q;
  logic [2:0]       sel_q;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q, nz_q, zero_q, sign_q, ovf_q;

  logic             accept_c, step_c, last_c;
  logic             slice_out, slice_cout;

  // Operands are shifted right each step, so the slice always sees bit 0
  alu_bit_slice u_slice (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .mode      (mode_q),
    .operation (sel_q),
    .cin       (cy_q),
    .out       (slice_out),
    .carry_out (slice_cout)
  );

  // Next-state and datapath strobes
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_c  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Request capture, serial shift/carry chain and flag capture on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      mode_q <= MODE_ARITH;
      sel_q  <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept_c) begin
      a_q    <= op_a;
      b_q    <= op_b;
      mode_q <= op_mode;
      sel_q  <= op_sel;
      cy_q   <= init_carry(op_mode, op_sel, op_cin);
      idx_q  <= '0;
      nz_q   <= 1'b0;
    end else if (step_c) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      res_q <= {slice_out, res_q[WIDTH-1:1]};
      cy_q  <= slice_cout;
      nz_q  <= nz_q | slice_out;
      idx_q <= idx_q + IDX_W'(1);
      if (last_c) begin
        zero_q <= ~(nz_q | slice_out);
        sign_q <= slice_out;
        ovf_q  <= (mode_q == MODE_ARITH) & (cy_q ^ slice_cout);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry     = cy_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal values: 2 to 32).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port op_mode, input, 1 bit: 0 = arithmetic, 1 = logic.
REQ-007 SHALL have port op_sel, input, 3 bits: operation code.
REQ-008 SHALL have port op_cin, input, 1 bit: carry-in, used only by ADC and SBB.
REQ-009 SHALL have ports op_a and op_b, input, WIDTH bits each: operands.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port result, output, WIDTH bits: result word.
REQ-013 SHALL have ports carry, zero, sign and overflow, output, 1 bit each: result flags.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; when in_valid=1 at a clock edge, SHALL latch op_mode, op_sel, op_a, op_b and the initial carry, clear the bit index, and move to RUN.
REQ-016 RUN: each edge SHALL process one bit, LSB first, through the bit slice. The result bit is shifted in at the MSB of the result register, the carry register is updated, and the index is incremented.
REQ-017 After the edge that processes bit WIDTH-1, SHALL move to DONE; out_valid rises exactly WIDTH edges after the accepting edge.
REQ-018 DONE: out_valid=1 with result and flags held stable until out_ready=1 at an edge; the FSM then SHALL return to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored there, and input changes after acceptance SHALL NOT affect the result.
REQ-020 Arithmetic second operand / initial carry by op_sel:
- 000 ADD: B / 0
- 001 SUB: ~B / 1
- 010 INC: 0 / 1
- 011 SBB: ~B / op_cin
- 100 PASS: 0 / 0
- 101 DEC: all-ones / 0
- 110 ADC: B / op_cin
- 111: 0 / 0
REQ-021 Logic by op_sel: 000 A&B, 001 A|B, 010 A^B, 011 ~A; 100-111 SHALL yield a result of 0.
REQ-022 carry SHALL be the final carry-out in arithmetic mode and 0 in logic mode; for SUB, carry=1 means no borrow.
REQ-023 zero SHALL be 1 exactly when result==0, accumulated serially by ORing the result bits.
REQ-024 sign SHALL equal result[WIDTH-1].
REQ-025 overflow SHALL be (carry into MSB) XOR (carry out of MSB) in arithmetic mode and 0 in logic mode.
REQ-026 If out_ready is held 1, DONE SHALL last exactly one cycle; the next acceptance is possible no earlier than the following edge, in IDLE.

Reset
REQ-027 While rst=1, SHALL force the FSM to IDLE and clear all of the following: result, carry, zero, sign, overflow, out_valid, the bit index and the carry register. in_ready SHALL be 1.
REQ-028 rst asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse; the first edge after release SHALL be able to accept a request.

Structure
REQ-029 Shared package alu_pkg SHALL hold the op_sel encodings, the mode constants and the FSM state enum.
REQ-030 SHALL instantiate one combinational sub-module alu_bit_slice with:
- inputs a, b, mode, operation and cin;
- outputs out and carry_out.
The second-operand selection of REQ-020 and the logic selection of REQ-021 are implemented inside the slice.
REQ-031 The bit index SHALL be $clog2(WIDTH) bits wide; no multi-bit adder SHALL exist outside the slice.

Verification (WIDTH=8)
REQ-032 ADD 0x7F+0x01 -> result 0x80, carry 0, overflow 1, sign 1, zero 0; out_valid exactly 8 edges after acceptance.
REQ-033 SUB 0x05-0x05 -> result 0x00, carry 1, zero 1, overflow 0; DEC 0x00 -> result 0xFF, carry 0, sign 1.
REQ-034 Logic XOR 0xA5,0xFF -> result 0x5A, carry 0, overflow 0; logic op_sel 101 -> result 0x00, zero 1.
REQ-035 ADC 0xFF+0x00 with op_cin=1 -> result 0x00, carry 1, zero 1; new operands with in_valid=1 during RUN are ignored and in_ready stays 0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable and out_valid held; release -> IDLE the next cycle.
REQ-037 rst pulsed after bit 3 of an ADD -> no out_valid; a following ADD 0x10+0x20 -> result 0x30.
